// File: rtl/lane_rr_scheduler.sv
// Four-lane round-robin byte scheduler with post-reset startup hold, idle fill
// and a link-idle detector. Grants are combinational; outputs are registered.
module lane_rr_scheduler #(
  parameter int         INIT_CYCLES = 4,
  parameter int         IDLE_LIMIT  = 8,
  parameter logic [7:0] IDLE_SYM    = 8'hBC
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  input  logic [3:0] lane_en,
  output logic [3:0] grant,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_id,
  output logic       link_idle
);

  localparam logic [0:0] STARTUP   = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;
  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [7:0] IDLE_MAX  = 8'(IDLE_LIMIT);

  logic [0:0] state_r;
  logic [1:0] ptr_r;
  logic [7:0] init_cnt_r;
  logic [7:0] idle_cnt_r;
  logic [7:0] idle_next_s;
  logic [7:0] data_sel_s;
  logic [3:0] req_s;
  logic [1:0] win_s;
  logic       found_s;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        pick = {1'b1, idx};
      end
    end
    return pick;
  endfunction

  // Request masking, winner selection, grant decode and idle counter increment.
  always_comb begin
    req_s = {valid_in3, valid_in2, valid_in1, valid_in0} & lane_en;
    if (state_r == RUN) begin
      {found_s, win_s} = rr_pick(req_s, ptr_r);
    end else begin
      {found_s, win_s} = 3'b000;
    end
    grant = 4'b0000;
    if (found_s) begin
      grant[win_s] = 1'b1;
    end else begin
      grant = 4'b0000;
    end
    case (win_s)
      2'd0:    data_sel_s = data_in0;
      2'd1:    data_sel_s = data_in1;
      2'd2:    data_sel_s = data_in2;
      2'd3:    data_sel_s = data_in3;
      default: data_sel_s = 8'h00;
    endcase
    if (idle_cnt_r >= IDLE_MAX) begin
      idle_next_s = IDLE_MAX;
    end else begin
      idle_next_s = idle_cnt_r + 8'd1;
    end
  end

  // Startup/run sequencing, output registers, pointer and idle tracking.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_r    <= STARTUP;
      ptr_r      <= 2'd0;
      init_cnt_r <= 8'd0;
      idle_cnt_r <= 8'd0;
      data_out   <= 8'h00;
      valid_out  <= 1'b0;
      lane_id    <= 2'd0;
      link_idle  <= 1'b0;
    end else begin
      case (state_r)
        STARTUP: begin
          valid_out  <= 1'b0;
          data_out   <= 8'h00;
          init_cnt_r <= init_cnt_r + 8'd1;
          if (init_cnt_r == INIT_LAST) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (found_s) begin
            data_out   <= data_sel_s;
            lane_id    <= win_s;
            valid_out  <= 1'b1;
            ptr_r      <= win_s + 2'd1;
            idle_cnt_r <= 8'd0;
            link_idle  <= 1'b0;
          end else begin
            valid_out  <= 1'b0;
            data_out   <= IDLE_SYM;
            idle_cnt_r <= idle_next_s;
            link_idle  <= (idle_next_s == IDLE_MAX);
          end
        end
        default: begin
          state_r <= STARTUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Directed bench for lane_rr_scheduler: stimulus pushes expected {lane, byte}
// into a queue, a negedge monitor pops and compares whenever valid_out is high.
module tb_lane_rr_scheduler;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic [7:0] dv [4];
  logic [3:0] vin;
  logic [3:0] lane_en;
  logic [3:0] grant;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_id;
  logic       link_idle;

  logic [9:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  always #5 clk_2f = ~clk_2f;

  lane_rr_scheduler dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .data_in0  (dv[0]),
    .data_in1  (dv[1]),
    .data_in2  (dv[2]),
    .data_in3  (dv[3]),
    .valid_in0 (vin[0]),
    .valid_in1 (vin[1]),
    .valid_in2 (vin[2]),
    .valid_in3 (vin[3]),
    .lane_en   (lane_en),
    .grant     (grant),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_id   (lane_id),
    .link_idle (link_idle)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < 4; i++) dv[i] = base + 8'(i);
  endtask

  // One cycle: drive requests, check the combinational grant, queue the expected output.
  task automatic step(input logic [3:0] v, input logic [3:0] en, input logic [3:0] exp_g,
                      input string name);
    logic [1:0] w;
    vin = v;
    lane_en = en;
    #2;
    check(name, 32'(grant), 32'(exp_g));
    if (exp_g != 4'b0000) begin
      w = oh2idx(exp_g);
      exp_q.push_back({w, dv[w]});
    end
    @(posedge clk_2f);
    #1;
  endtask

  // Monitor: every valid output must match the oldest queued expectation.
  always @(negedge clk_2f) begin
    logic [9:0] e;
    if (!reset && valid_out) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got lane %0d data %0h, expected no output", lane_id, data_out);
      end else begin
        e = exp_q.pop_front();
        check("out_lane_data", 32'({lane_id, data_out}), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    vin = 4'hF;
    lane_en = 4'hF;
    set_data(8'h10);
    repeat (3) @(posedge clk_2f);
    #1;
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_grant", 32'(grant), 0);
    reset = 1'b0;

    // 1. Startup hold: four cycles without grants, then lane 0
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 4'hF, 4'b0000, "startup_grant");
      check("startup_valid_out", 32'(valid_out), 0);
      check("startup_data_out", 32'(data_out), 0);
    end
    step(4'hF, 4'hF, 4'b0001, "first_grant");

    // 2. Full round robin
    step(4'hF, 4'hF, 4'b0010, "rr1");
    step(4'hF, 4'hF, 4'b0100, "rr2");
    check("rr_valid_cont", 32'(valid_out), 1);
    step(4'hF, 4'hF, 4'b1000, "rr3");
    step(4'hF, 4'hF, 4'b0001, "rr0");
    step(4'hF, 4'hF, 4'b0010, "rr1b");
    step(4'hF, 4'hF, 4'b0100, "rr2b");
    step(4'hF, 4'hF, 4'b1000, "rr3b");

    // 3. Sparse requests and pointer wrap (ptr 0 -> 0 -> 2 -> 3)
    set_data(8'hA0);
    step(4'b1000, 4'hF, 4'b1000, "sparse_l3");
    step(4'b0010, 4'hF, 4'b0010, "sparse_l1");
    step(4'hF, 4'hF, 4'b0100, "ptr_after_l1");

    // 4. Mask 1010: lanes 1 and 3 only; then an all-zero mask
    set_data(8'hC0);
    step(4'hF, 4'b1010, 4'b1000, "mask_a");
    step(4'hF, 4'b1010, 4'b0010, "mask_b");
    step(4'hF, 4'b1010, 4'b1000, "mask_c");
    step(4'hF, 4'b1010, 4'b0010, "mask_d");
    step(4'hF, 4'b0000, 4'b0000, "mask_zero");
    check("mask_zero_valid", 32'(valid_out), 0);
    check("mask_zero_fill", 32'(data_out), 32'h00BC);
    step(4'b0100, 4'hF, 4'b0100, "grant_before_idle");

    // 5. Idle fill and link_idle at the eighth no-grant edge
    for (int k = 1; k <= 10; k++) begin
      step(4'b0000, 4'hF, 4'b0000, "idle_grant");
      check("idle_fill", 32'(data_out), 32'h00BC);
      check("idle_valid", 32'(valid_out), 0);
      check("link_idle", 32'(link_idle), (k >= 8) ? 1 : 0);
    end
    set_data(8'h50);
    step(4'b0001, 4'hF, 4'b0001, "wake_grant");
    check("link_idle_clear", 32'(link_idle), 0);

    // 6. Reset mid-stream
    set_data(8'hE0);
    step(4'hF, 4'hF, 4'b0010, "pre_rst1");
    step(4'hF, 4'hF, 4'b0100, "pre_rst2");
    #6;
    reset = 1'b1;
    #1;
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_valid_out", 32'(valid_out), 0);
    check("midrst_lane_id", 32'(lane_id), 0);
    check("midrst_grant", 32'(grant), 0);
    repeat (2) @(posedge clk_2f);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 4'hF, 4'b0000, "restart_hold");
      check("restart_valid_out", 32'(valid_out), 0);
    end
    step(4'hF, 4'hF, 4'b0001, "restart_lane0");
    step(4'hF, 4'hF, 4'b0010, "restart_lane1");
    step(4'b0000, 4'hF, 4'b0000, "drain1");
    step(4'b0000, 4'hF, 4'b0000, "drain2");
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
